e203_ifu_flush_ctrl: RTL and testbench
======================================

// Module: e203_ifu_flush_ctrl
// PURPOSE
//  Receives the commit-stage pipeline flush (pipe_flush_req/add_op1/add_op2) and redirects instruction fetch.
//  Computes the flush PC, holds one pending flush, and blocks normal sequential fetch during a flush.
//  Counts outstanding fetch requests and discards responses to requests issued before the flush.
//  Issues the flush-target fetch only after those stale responses have drained.
//  Sits between the commit stage and the IFU fetch-bus adaptor.
// PARAMETERS
//  CNT_W         2  width of outstanding-fetch counter; max outstanding = 2**CNT_W-1
//  USE_FLUSH_PC  0  1: use pipe_flush_pc directly (E203_TIMING_BOOST build); 0: pc = op1+op2
// PORTS
//  clk                 in   1            core clock
//  rst_n               in   1            async reset, active low
//  pipe_flush_req      in   1            flush request from commit
//  pipe_flush_ack      out  1            flush accepted; constant 1 out of reset
//  pipe_flush_add_op1  in   PC_SIZE      flush adder operand 1
//  pipe_flush_add_op2  in   PC_SIZE      flush adder operand 2
//  pipe_flush_pc       in   PC_SIZE      precomputed flush PC (used only if USE_FLUSH_PC=1)
//  nrml_req_valid      in   1            sequential fetch request from IFU PC generator
//  nrml_req_ready      out  1            sequential fetch accepted
//  nrml_req_pc         in   PC_SIZE      sequential fetch PC
//  ifu_req_valid       out  1            fetch request to bus adaptor
//  ifu_req_ready       in   1            bus adaptor accepts request
//  ifu_req_pc          out  PC_SIZE      fetch address
//  ifu_req_flush       out  1            current request is a flush-target fetch
//  ifu_rsp_valid       in   1            fetch response from bus (in-order, always accepted)
//  o_rsp_valid         out  1            response forwarded to IFU; 0 when dropped
//  flush_busy          out  1            state != IDLE; IFU must not advance its PC
// BEHAVIOUR
//  Reset: state=IDLE, pend_pc=0, cnt=0; ifu_req_valid=0, o_rsp_valid=0, flush_busy=0, pipe_flush_ack=1.
//  Flush pulse: fp = pipe_flush_req. flush_pc = op1+op2, truncated to PC_SIZE (carry dropped), or pipe_flush_pc.
//  Counter: cnt += (ifu_req_valid & ifu_req_ready); cnt -= ifu_rsp_valid; both in one cycle -> unchanged.
//  Full: cnt == 2**CNT_W-1 blocks all new ifu requests (valid=0).
//  IDLE: ifu_req mirrors nrml_req (valid & ~fp & ~full); nrml_req_ready = ifu_req_ready & ~fp & ~full.
//  IDLE: o_rsp_valid = ifu_rsp_valid.
//  On fp, latch pend_pc; go to ISSUE if next cnt == 0, else DRAIN.
//  DRAIN: nrml_req_ready=0; ifu_req_valid=0; o_rsp_valid=0 (drop).
//  DRAIN exits to ISSUE in the cycle after next cnt reaches 0.
//  ISSUE: ifu_req_valid=1, ifu_req_pc=pend_pc, ifu_req_flush=1; responses dropped (cnt==0 here, none expected).
//  ISSUE: on handshake -> IDLE; the flush-target response is then forwarded normally.
//  Latency: fp at cycle T with cnt=0 -> flush request valid at T+1.
//  fp during DRAIN: overwrite pend_pc, stay DRAIN.
//  fp during ISSUE without handshake: overwrite pend_pc, stay ISSUE.
//  Exception: in ISSUE, ifu_req_pc may change while valid is held.
//  fp in the same cycle as the ISSUE handshake: latch new pc and go to DRAIN (cnt becomes 1; old target response dropped).
//  Response and fp in the same cycle in IDLE: that response is still forwarded (it predates the flush decision).
//  Reset mid-operation returns to IDLE immediately with cnt=0; stale bus responses after reset are the adaptor's job.
//  Assertions: cnt never underflows (rsp with cnt==0); ifu_req_flush implies state==ISSUE.
// STRUCTURE
//  PC_SIZE comes from E203_PC_SIZE (e203_defines.v).
//  State encoding (IDLE/DRAIN/ISSUE, 2 bits) as localparams in the shared defines file: E203_IFU_FLSH_*.
//  Sub-module: e203_ifu_outs_cnt: up/down counter with full/zero flags, width CNT_W.
//  Flops use the codebase sirv_gnrl_dfflr/dfflrs cells with rst_n.
// TESTING
//  1. cnt=0, flush op1=0x8000_0000, op2=0x10 -> at T+1 ifu_req_valid=1, pc=0x8000_0010, flush=1.
//  2. Two requests outstanding, then flush -> next two rsp have o_rsp_valid=0; flush request issued the cycle after the 2nd rsp.
//  3. Flush 0x100 during DRAIN, then flush 0x200 -> the only flush request issued has pc=0x200.
//  4. ISSUE with ifu_req_ready=1 and new flush (0x300) in the same cycle -> DRAIN; old target rsp dropped; 0x300 issued.
//  5. CNT_W=2: three requests without responses -> nrml_req_ready=0; one rsp -> ready returns.
//  6. rst_n asserted while in DRAIN -> next cycle state IDLE, cnt=0, all valid outputs 0.

Source files
------------

// File: rtl/e203_ifu_flush_ctrl_pkg.sv
// Shared types and constants for the IFU flush controller.
package e203_ifu_flush_ctrl_pkg;

    localparam int unsigned PC_SIZE = 32;
    localparam int unsigned FLSH_STATE_W = 2;

    typedef enum logic [FLSH_STATE_W-1:0] {
        E203_IFU_FLSH_IDLE  = 2'd0,
        E203_IFU_FLSH_DRAIN = 2'd1,
        E203_IFU_FLSH_ISSUE = 2'd2
    } flsh_state_e;

    typedef struct packed {
        logic [PC_SIZE-1:0] pc;
        logic               flush;
    } ifu_req_t;

    // Flush target; the adder carry is dropped so the PC wraps.
    function automatic logic [PC_SIZE-1:0] flush_pc_calc(input logic [PC_SIZE-1:0] op1,
                                                         input logic [PC_SIZE-1:0] op2);
        return op1 + op2;
    endfunction

endpackage

// File: rtl/e203_ifu_flush_ctrl_if.sv
// Commit-flush, sequential-fetch and fetch-bus signals seen by the flush controller.
interface e203_ifu_flush_ctrl_if;
    import e203_ifu_flush_ctrl_pkg::*;

    logic               pipe_flush_req;
    logic               pipe_flush_ack;
    logic [PC_SIZE-1:0] pipe_flush_add_op1;
    logic [PC_SIZE-1:0] pipe_flush_add_op2;
    logic [PC_SIZE-1:0] pipe_flush_pc;
    logic               nrml_req_valid;
    logic               nrml_req_ready;
    logic [PC_SIZE-1:0] nrml_req_pc;
    logic               ifu_req_valid;
    logic               ifu_req_ready;
    logic [PC_SIZE-1:0] ifu_req_pc;
    logic               ifu_req_flush;
    logic               ifu_rsp_valid;
    logic               o_rsp_valid;
    logic               flush_busy;

    modport slave (
        input  pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2, pipe_flush_pc,
        input  nrml_req_valid, nrml_req_pc, ifu_req_ready, ifu_rsp_valid,
        output pipe_flush_ack, nrml_req_ready, ifu_req_valid, ifu_req_pc, ifu_req_flush,
        output o_rsp_valid, flush_busy
    );

    modport master (
        output pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2, pipe_flush_pc,
        output nrml_req_valid, nrml_req_pc, ifu_req_ready, ifu_rsp_valid,
        input  pipe_flush_ack, nrml_req_ready, ifu_req_valid, ifu_req_pc, ifu_req_flush,
        input  o_rsp_valid, flush_busy
    );

endinterface

// File: rtl/e203_ifu_outs_cnt.sv
// Outstanding fetch counter: +1 per accepted request, -1 per response.
module e203_ifu_outs_cnt #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full_c,
    output logic nxt_zero_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign full_c     = &cnt_q;
    assign nxt_zero_c = (cnt_d == '0);

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        dec |-> (cnt_q != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (inc && !dec) |-> !full_c);

endmodule

// File: rtl/e203_ifu_flush_ctrl.sv
// Redirects IFU fetch on a commit flush: drops stale responses, then issues the flush target.
module e203_ifu_flush_ctrl
    import e203_ifu_flush_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 2,
    parameter bit          USE_FLUSH_PC = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    e203_ifu_flush_ctrl_if.slave  bus
);

    flsh_state_e        state_q, state_d;
    logic [PC_SIZE-1:0] pend_pc_q, pend_pc_d;
    logic [PC_SIZE-1:0] flush_pc;
    logic               fp;
    logic               full_c;
    logic               nxt_zero_c;
    logic               req_vld_c;
    logic               nrml_rdy;
    logic               rsp_fwd;
    ifu_req_t           req;

    assign fp       = bus.pipe_flush_req;
    assign flush_pc = USE_FLUSH_PC ? bus.pipe_flush_pc
                                   : flush_pc_calc(bus.pipe_flush_add_op1, bus.pipe_flush_add_op2);

    // Request valid kept out of the FSM block: the counter's next value feeds back into it.
    assign req_vld_c = (state_q == E203_IFU_FLSH_ISSUE)
                     | ((state_q == E203_IFU_FLSH_IDLE) & bus.nrml_req_valid & ~fp & ~full_c);

    e203_ifu_outs_cnt #(.CNT_W(CNT_W)) u_outs_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (req_vld_c & bus.ifu_req_ready),
        .dec        (bus.ifu_rsp_valid),
        .full_c     (full_c),
        .nxt_zero_c (nxt_zero_c)
    );

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        req       = '{pc: bus.nrml_req_pc, flush: 1'b0};
        nrml_rdy  = 1'b0;
        rsp_fwd   = 1'b0;
        unique case (state_q)
            E203_IFU_FLSH_IDLE: begin
                nrml_rdy = bus.ifu_req_ready & ~fp & ~full_c;
                // A response in the flush cycle predates the flush and is still delivered.
                rsp_fwd  = bus.ifu_rsp_valid;
                if (fp) begin
                    pend_pc_d = flush_pc;
                    state_d   = nxt_zero_c ? E203_IFU_FLSH_ISSUE : E203_IFU_FLSH_DRAIN;
                end
            end
            E203_IFU_FLSH_DRAIN: begin
                if (fp)         pend_pc_d = flush_pc;
                if (nxt_zero_c) state_d   = E203_IFU_FLSH_ISSUE;
            end
            E203_IFU_FLSH_ISSUE: begin
                req = '{pc: pend_pc_q, flush: 1'b1};
                if (fp) pend_pc_d = flush_pc;
                // A new flush racing the handshake makes the just-issued target stale.
                if (bus.ifu_req_ready) state_d = fp ? E203_IFU_FLSH_DRAIN : E203_IFU_FLSH_IDLE;
            end
            default: state_d = E203_IFU_FLSH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= E203_IFU_FLSH_IDLE;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign bus.pipe_flush_ack = 1'b1;
    assign bus.ifu_req_valid  = req_vld_c;
    assign bus.ifu_req_pc     = req.pc;
    assign bus.ifu_req_flush  = req.flush;
    assign bus.nrml_req_ready = nrml_rdy;
    assign bus.o_rsp_valid    = rsp_fwd;
    assign bus.flush_busy     = (state_q != E203_IFU_FLSH_IDLE);

    a_flush_in_issue: assert property (@(posedge clk) disable iff (!rst_n)
        bus.ifu_req_flush |-> (state_q == E203_IFU_FLSH_ISSUE));

endmodule

// File: tb/tb_e203_ifu_flush_ctrl.sv
// Cycle-vector bench for e203_ifu_flush_ctrl with an expected-output queue.
module tb_e203_ifu_flush_ctrl;
    import e203_ifu_flush_ctrl_pkg::*;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic        flush;
        logic        nrdy;
        logic        orsp;
        logic        busy;
        logic        ack;
    } obs_t;

    typedef struct {
        string       name;
        logic        fp;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        nv;
        logic [31:0] npc;
        logic        rdy;
        logic        rsp;
        obs_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    obs_t  exp_q[$];
    string name_q[$];
    vec_t  tbl[$];

    always #5 clk = ~clk;

    e203_ifu_flush_ctrl_if bus_if();

    e203_ifu_flush_ctrl #(.CNT_W(2), .USE_FLUSH_PC(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    function automatic vec_t mk(input string name, input logic fp, input logic [31:0] op1,
                                input logic [31:0] op2, input logic nv, input logic [31:0] npc,
                                input logic rdy, input logic rsp, input logic evld,
                                input logic [31:0] epc, input logic eflush, input logic enrdy,
                                input logic eorsp, input logic ebusy);
        vec_t v;
        v.name = name; v.fp = fp; v.op1 = op1; v.op2 = op2;
        v.nv = nv; v.npc = npc; v.rdy = rdy; v.rsp = rsp;
        v.exp = '{vld: evld, pc: evld ? epc : 32'h0, flush: eflush, nrdy: enrdy,
                  orsp: eorsp, busy: ebusy, ack: 1'b1};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus_if.pipe_flush_req     = v.fp;
        bus_if.pipe_flush_add_op1 = v.op1;
        bus_if.pipe_flush_add_op2 = v.op2;
        bus_if.pipe_flush_pc      = 32'hDEAD_BEE0;
        bus_if.nrml_req_valid     = v.nv;
        bus_if.nrml_req_pc        = v.npc;
        bus_if.ifu_req_ready      = v.rdy;
        bus_if.ifu_rsp_valid      = v.rsp;
    endtask

    task automatic check_out();
        obs_t  e;
        obs_t  a;
        string n;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = '{vld: bus_if.ifu_req_valid, pc: bus_if.ifu_req_pc, flush: bus_if.ifu_req_flush,
              nrdy: bus_if.nrml_req_ready, orsp: bus_if.o_rsp_valid, busy: bus_if.flush_busy,
              ack: bus_if.pipe_flush_ack};
        if (!e.vld) a.pc = 32'h0;
        if (a !== e)
            $display("FAIL %s: got vld=%0b pc=%h flush=%0b nrdy=%0b orsp=%0b busy=%0b ack=%0b, required vld=%0b pc=%h flush=%0b nrdy=%0b orsp=%0b busy=%0b ack=%0b",
                     n, a.vld, a.pc, a.flush, a.nrdy, a.orsp, a.busy, a.ack,
                     e.vld, e.pc, e.flush, e.nrdy, e.orsp, e.busy, e.ack);
        else
            passed++;
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk); #1;
        drive(v);
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        vec_t z;
        z = mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(z);
        rst_n = 1'b0;

        // name fp op1 op2 nv npc rdy rsp | vld pc flush nrdy orsp busy
        tbl.push_back(mk("idle_fetch",       0, 0, 0, 1, 32'h1000, 1, 0, 1, 32'h1000, 0, 1, 0, 0));
        tbl.push_back(mk("idle_rsp",         0, 0, 0, 0, 0,        1, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk("t1_flush",         1, 32'h8000_0000, 32'h10, 1, 32'h2000, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t1_issue_wait",    0, 0, 0, 1, 32'h2000, 0, 0, 1, 32'h8000_0010, 1, 0, 0, 1));
        tbl.push_back(mk("t1_issue_hsk",     0, 0, 0, 1, 32'h2000, 1, 0, 1, 32'h8000_0010, 1, 0, 0, 1));
        tbl.push_back(mk("t1_target_rsp",    0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("t2_req_a",         0, 0, 0, 1, 32'h3000, 1, 0, 1, 32'h3000, 0, 1, 0, 0));
        tbl.push_back(mk("t2_req_b",         0, 0, 0, 1, 32'h3004, 1, 0, 1, 32'h3004, 0, 1, 0, 0));
        tbl.push_back(mk("t2_flush",         1, 32'h100, 32'h20, 1, 32'h3008, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t2_drain_hold",    0, 0, 0, 1, 32'h3008, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("t2_drop_rsp1",     0, 0, 0, 1, 32'h3008, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("t2_drop_rsp2",     0, 0, 0, 1, 32'h3008, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("t2_issue",         0, 0, 0, 1, 32'h3008, 1, 0, 1, 32'h120, 1, 0, 0, 1));
        tbl.push_back(mk("t2_target_rsp",    0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("t3_req",           0, 0, 0, 1, 32'h4000, 1, 0, 1, 32'h4000, 0, 1, 0, 0));
        tbl.push_back(mk("t3_flush_first",   1, 32'h50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t3_flush_100",     1, 32'h80, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("t3_flush_200",     1, 32'h1F0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("t3_drop_rsp",      0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("t3_issue",         0, 0, 0, 0, 0,        1, 0, 1, 32'h200, 1, 0, 0, 1));
        tbl.push_back(mk("t3_target_rsp",    0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("t4_flush",         1, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t4_issue_fp",      1, 32'h600, 0, 0, 0, 0, 0, 1, 32'h500, 1, 0, 0, 1));
        tbl.push_back(mk("t4_issue_hsk_fp",  1, 32'h300, 0, 0, 0, 1, 0, 1, 32'h600, 1, 0, 0, 1));
        tbl.push_back(mk("t4_drain",         0, 0, 0, 1, 32'h4100, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("t4_drop_old_tgt",  0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("t4_issue_300",     0, 0, 0, 0, 0,        1, 0, 1, 32'h300, 1, 0, 0, 1));
        tbl.push_back(mk("t4_target_rsp",    0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("carry_flush",      1, 32'hFFFF_FFF0, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("carry_issue",      0, 0, 0, 0, 0,        1, 0, 1, 32'h10, 1, 0, 0, 1));
        tbl.push_back(mk("carry_rsp",        0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("t5_req1",          0, 0, 0, 1, 32'h5000, 1, 0, 1, 32'h5000, 0, 1, 0, 0));
        tbl.push_back(mk("t5_req2",          0, 0, 0, 1, 32'h5004, 1, 0, 1, 32'h5004, 0, 1, 0, 0));
        tbl.push_back(mk("t5_req3",          0, 0, 0, 1, 32'h5008, 1, 0, 1, 32'h5008, 0, 1, 0, 0));
        tbl.push_back(mk("t5_full",          0, 0, 0, 1, 32'h500C, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t5_rsp_full",      0, 0, 0, 1, 32'h500C, 1, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("t5_ready_back",    0, 0, 0, 1, 32'h500C, 1, 1, 1, 32'h500C, 0, 1, 1, 0));
        tbl.push_back(mk("t5_rsp",           0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("rsp_fp_same",      1, 32'h700, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("rsp_fp_issue",     0, 0, 0, 0, 0,        1, 0, 1, 32'h700, 1, 0, 0, 1));
        tbl.push_back(mk("rsp_fp_target",    0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("t6_req",           0, 0, 0, 1, 32'h6000, 1, 0, 1, 32'h6000, 0, 1, 0, 0));
        tbl.push_back(mk("t6_flush",         1, 32'h800, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t6_drain",         0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 1));

        // Outputs while held in reset.
        repeat (2) @(posedge clk);
        exp_q.push_back(z.exp);
        name_q.push_back("reset_state");
        @(negedge clk);
        check_out();
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Reset asserted while draining: IDLE at once, counter cleared.
        @(posedge clk); #1;
        drive(z);
        rst_n = 1'b0;
        exp_q.push_back(z.exp);
        name_q.push_back("t6_reset_in_drain");
        @(negedge clk);
        check_out();
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(mk("t6_after_reset", 0, 0, 0, 1, 32'h6004, 1, 0, 1, 32'h6004, 0, 1, 0, 0));
        apply(mk("t6_cnt_cleared",  1, 32'h900, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        apply(mk("t6_issue",        0, 0, 0, 0, 0, 1, 0, 1, 32'h900, 1, 0, 0, 1));
        apply(mk("t6_target_rsp",   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));

        @(posedge clk); #1;
        drive(z);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
